mpu_bus_sync: RTL and testbench
===============================

# mpu_bus_sync

Clock-domain bridge between the AVR-style pin-level bus conversion and the ChronoCube core. It synchronizes the asynchronous `_mpu_rd`/`_mpu_wr` strobes into `clk` and captures address, write data and byte enables. For each strobe it issues exactly one request/acknowledge transaction to the core, then holds read data stable for the pin-side output mux.

## Interface

Parameters:
- `ADDR_WIDTH`, 16, word address width toward the core.
- `DATA_WIDTH`, 16, core data width.
- `SYNC_STAGES`, 2, flops per strobe synchronizer; legal values are 2 or greater.

Ports:
- `clk`  in  1  system clock; one clock domain. All state is on its rising edge.
- `_reset`  in  1  reset, asynchronous assert, active-low.
- `_mpu_rd`  in  1  read strobe from the pins, active-low, asynchronous to `clk`.
- `_mpu_wr`  in  1  write strobe from the pins, active-low, asynchronous to `clk`.
- `_mpu_be`  in  2  byte enables, active-low, stable while a strobe is asserted.
- `mpu_addr_in`  in  ADDR_WIDTH  word address, stable while a strobe is asserted.
- `mpu_data_in`  in  DATA_WIDTH  write data, stable while `_mpu_wr` is asserted.
- `mpu_data_out`  out  DATA_WIDTH  registered read data to the pin-side byte mux.
- `mpu_busy`  out  1  high whenever the FSM is not in IDLE.
- `core_req`  out  1  request to the core, level-held until acknowledged.
- `core_wr`  out  1  1 = write, 0 = read; valid while `core_req` is high.
- `core_addr`  out  ADDR_WIDTH  captured address.
- `core_wdata`  out  DATA_WIDTH  captured write data.
- `core_be`  out  2  captured byte enables, active-high (inverted `_mpu_be`).
- `core_ack`  in  1  single-cycle acknowledge from the core.
- `core_rdata`  in  DATA_WIDTH  read data; valid in the cycle `core_ack` is high.

## Operation

- Synchronizers: each strobe passes through `SYNC_STAGES` flops, reset to 1 (inactive). Define `rd_s` = not(synced `_mpu_rd`) and `wr_s` = not(synced `_mpu_wr`).
- Reset state: RELEASE. Reset values: `core_req`=0, `core_wr`=0, `core_addr`=0, `core_wdata`=0, `core_be`=0, `mpu_data_out`=0, `mpu_busy`=1 (it drops once RELEASE exits).
- FSM:
  - **IDLE:** if `rd_s` XOR `wr_s`, then register `mpu_addr_in`, `mpu_data_in`, ~`_mpu_be`, set `core_wr`=`wr_s`, set `core_req`=1, and go to REQ. If both are high, no access is made and the FSM stays in IDLE. If neither is high, it stays in IDLE.
  - **REQ:** hold `core_req` and all `core_*` outputs constant. On `core_ack`=1:
    - clear `core_req` at that edge;
    - if this is a read, load `core_rdata` into `mpu_data_out`;
    - go to RELEASE.
  - **RELEASE:** stay until `rd_s`=0 and `wr_s`=0, then go to IDLE.
- One strobe assertion produces exactly one core transaction.
- A strobe released before `core_ack` does not abort the transaction. The request completes and RELEASE exits on the next cycle.
- Switching from rd directly to wr (no both-inactive gap) is not a new access, because RELEASE requires both inactive.
- `core_ack` outside REQ is ignored.
- `mpu_data_out` changes only on a read ack. Writes never modify it.
- Reset mid-transaction: `core_req` drops asynchronously and the FSM goes to RELEASE. A strobe held through reset release is therefore ignored until it deasserts.

## Timing

- Strobe falls before edge 0 → `rd_s`/`wr_s` high after edge `SYNC_STAGES-1` → capture and `core_req`=1 after edge `SYNC_STAGES`. That is `SYNC_STAGES+1` edges from the strobe to the request.
- Address and data must be stable from strobe assertion through the capture edge. The MPU side inserts wait states to guarantee this.
- Core ack in cycle N → `core_req`=0 and `mpu_data_out` valid after edge N.
- Minimum read latency, strobe to valid `mpu_data_out`, is `SYNC_STAGES+2` edges with a zero-wait core.
- `mpu_busy` is registered, i.e. decoded from the state register, and carries no combinational path from the inputs.

## Test plan

- **Reset and IDLE:** assert `_reset`=0 with random inputs → all outputs at their reset values and `core_req`=0. Release reset with strobes high → `mpu_busy` falls after 1 edge.
- **Write:** `_mpu_wr`=0, addr=0x1234, data=0xBEEF, `_mpu_be`=2'b10 → `core_req`=1 after 3 edges with `core_wr`=1, `core_addr`=0x1234, `core_wdata`=0xBEEF, `core_be`=2'b01. Ack after 4 cycles → `core_req` drops. Exactly one request is issued for the whole strobe.
- **Read:** `_mpu_rd`=0, addr=0x0042, core acks with 0xA55A → `mpu_data_out`=0xA55A on the edge after the ack. A following write leaves it at 0xA55A.
- **Simultaneous strobes:** `_mpu_rd`=`_mpu_wr`=0 for 10 cycles → no `core_req` and the FSM stays in IDLE.
- **Early release and back-to-back:** strobe released while in REQ, ack arrives 5 cycles later → one transaction, then IDLE. A read followed immediately by a write with no gap → only the read is issued.
- **Reset mid-op:** `_reset`=0 while in REQ → `core_req`=0 immediately. Strobe held across reset release → no new request until the strobe deasserts and reasserts.

Source files
------------

// File: rtl/mpu_bus_sync.sv
`default_nettype none
// ============================================================================
// mpu_bus_sync : syncs async MPU strobes into clk, one core req/ack per strobe
// Revision     : 1.0
// ============================================================================
module mpu_bus_sync #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  _mpu_rd,
    input  logic                  _mpu_wr,
    input  logic [1:0]            _mpu_be,
    input  logic [ADDR_WIDTH-1:0] mpu_addr_in,
    input  logic [DATA_WIDTH-1:0] mpu_data_in,
    output logic [DATA_WIDTH-1:0] mpu_data_out,
    output logic                  mpu_busy,
    output logic                  core_req,
    output logic                  core_wr,
    output logic [ADDR_WIDTH-1:0] core_addr,
    output logic [DATA_WIDTH-1:0] core_wdata,
    output logic [1:0]            core_be,
    input  logic                  core_ack,
    input  logic [DATA_WIDTH-1:0] core_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  rd_sync_q;
    logic [SYNC_STAGES-1:0]  wr_sync_q;
    logic [SYNC_STAGES-1:0]  prime_q;
    logic                    armed_q;
    logic                    core_req_q;
    logic                    core_wr_q;
    logic [ADDR_WIDTH-1:0]   core_addr_q;
    logic [DATA_WIDTH-1:0]   core_wdata_q;
    logic [1:0]              core_be_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    rd_s;
    logic                    wr_s;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rd_sync_q <= '1;
            wr_sync_q <= '1;
            prime_q   <= '0;
        end else begin
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], _mpu_rd};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], _mpu_wr};
            prime_q   <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rd_s = ~rd_sync_q[SYNC_STAGES-1];
    assign wr_s = ~wr_sync_q[SYNC_STAGES-1];

    // Synchronizer flops reset to "inactive", so a strobe held through reset
    // only becomes visible once the pipeline has refilled. Accesses are
    // therefore armed only after a genuinely idle sample has been seen.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= RELEASE;
            armed_q      <= 1'b0;
            core_req_q   <= 1'b0;
            core_wr_q    <= 1'b0;
            core_addr_q  <= '0;
            core_wdata_q <= '0;
            core_be_q    <= 2'b00;
            data_out_q   <= '0;
        end else begin
            if (!armed_q && prime_q[SYNC_STAGES-1] && !rd_s && !wr_s) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (armed_q && (rd_s ^ wr_s)) begin
                        core_addr_q  <= mpu_addr_in;
                        core_wdata_q <= mpu_data_in;
                        core_be_q    <= ~_mpu_be;
                        core_wr_q    <= wr_s;
                        core_req_q   <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (core_ack) begin
                        core_req_q <= 1'b0;
                        if (!core_wr_q) begin
                            data_out_q <= core_rdata;
                        end
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!rd_s && !wr_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= RELEASE;
            endcase
        end
    end

    assign mpu_busy     = (state_q != IDLE);
    assign core_req     = core_req_q;
    assign core_wr      = core_wr_q;
    assign core_addr    = core_addr_q;
    assign core_wdata   = core_wdata_q;
    assign core_be      = core_be_q;
    assign mpu_data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mpu_bus_sync.sv
`default_nettype none
// ============================================================================
// tb_mpu_bus_sync : scoreboard bench for mpu_bus_sync
// Revision        : 1.0
// ============================================================================
module tb_mpu_bus_sync;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mpu_rd_n;
    logic          mpu_wr_n;
    logic [1:0]    mpu_be_n;
    logic [AW-1:0] mpu_addr_in;
    logic [DW-1:0] mpu_data_in;
    logic [DW-1:0] mpu_data_out;
    logic          mpu_busy;
    logic          core_req;
    logic          core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [1:0]    core_be;
    logic          core_ack;
    logic [DW-1:0] core_rdata;

    int checks = 0;
    int errors = 0;
    int n_req  = 0;
    int n0;
    logic          req_prev = 1'b0;
    logic [34:0]   exp_q[$];

    always #5 clk = ~clk;

    mpu_bus_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) u_dut (
        .clk          (clk),
        ._reset       (reset_n),
        ._mpu_rd      (mpu_rd_n),
        ._mpu_wr      (mpu_wr_n),
        ._mpu_be      (mpu_be_n),
        .mpu_addr_in  (mpu_addr_in),
        .mpu_data_in  (mpu_data_in),
        .mpu_data_out (mpu_data_out),
        .mpu_busy     (mpu_busy),
        .core_req     (core_req),
        .core_wr      (core_wr),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_be      (core_be),
        .core_ack     (core_ack),
        .core_rdata   (core_rdata)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Every rising edge of core_req must match the oldest pending access.
    always @(negedge clk) begin
        if (core_req && !req_prev) begin
            n_req = n_req + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_req", 64'd1, 64'd0);
            end else begin
                check("req_fields", {29'd0, core_wr, core_addr, core_wdata, core_be},
                      {29'd0, exp_q.pop_front()});
            end
        end
        req_prev <= core_req;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!core_req && n < 20) begin
            cyc(1);
            n++;
        end
        check("req_seen", core_req, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mpu_busy && n < 20) begin
            cyc(1);
            n++;
        end
        check("idle_seen", mpu_busy, 0);
    endtask

    task automatic do_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [1:0] ben, input int dly, input logic [DW-1:0] rd,
                             input bit early);
        mpu_addr_in = a;
        mpu_data_in = d;
        mpu_be_n    = ben;
        exp_q.push_back({wr, a, d, ~ben});
        if (wr) mpu_wr_n = 1'b0;
        else    mpu_rd_n = 1'b0;
        wait_req();
        if (early) begin
            mpu_rd_n = 1'b1;
            mpu_wr_n = 1'b1;
        end
        cyc(dly);
        core_ack   = 1'b1;
        core_rdata = rd;
        cyc(1);
        core_ack   = 1'b0;
        core_rdata = DW'($urandom);
        check("req_drop", core_req, 0);
        if (!wr) check("rd_data", mpu_data_out, rd);
        mpu_rd_n = 1'b1;
        mpu_wr_n = 1'b1;
        wait_idle();
    endtask

    initial begin
        reset_n     = 1'b0;
        mpu_rd_n    = 1'($urandom);
        mpu_wr_n    = 1'($urandom);
        mpu_be_n    = 2'($urandom);
        mpu_addr_in = AW'($urandom);
        mpu_data_in = DW'($urandom);
        core_ack    = 1'($urandom);
        core_rdata  = DW'($urandom);
        cyc(3);
        check("rst_req", core_req, 0);
        check("rst_wr", core_wr, 0);
        check("rst_addr", core_addr, 0);
        check("rst_wdata", core_wdata, 0);
        check("rst_be", core_be, 0);
        check("rst_dout", mpu_data_out, 0);
        check("rst_busy", mpu_busy, 1);

        mpu_rd_n = 1'b1;
        mpu_wr_n = 1'b1;
        core_ack = 1'b0;
        reset_n  = 1'b1;
        #1;
        check("busy_at_release", mpu_busy, 1);
        cyc(1);
        check("busy_after_1", mpu_busy, 0);
        cyc(4);

        // Write with exact request latency and a 4-cycle ack delay
        n0 = n_req;
        mpu_addr_in = 16'h1234;
        mpu_data_in = 16'hBEEF;
        mpu_be_n    = 2'b10;
        exp_q.push_back({1'b1, 16'h1234, 16'hBEEF, 2'b01});
        mpu_wr_n = 1'b0;
        cyc(2);
        check("wr_req_early", core_req, 0);
        cyc(1);
        check("wr_req_lat", core_req, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("wr_req_hold", {core_req, core_wr, core_addr}, {1'b1, 1'b1, 16'h1234});
        end
        core_ack = 1'b1;
        cyc(1);
        core_ack = 1'b0;
        check("wr_req_drop", core_req, 0);
        check("wr_busy_release", mpu_busy, 1);
        cyc(5);
        check("wr_one_req", n_req, n0 + 1);
        check("wr_dout_keep", mpu_data_out, 0);
        mpu_wr_n = 1'b1;
        wait_idle();

        // Read, then a write that must not disturb the read data
        do_access(1'b0, 16'h0042, 16'h0000, 2'b00, 0, 16'hA55A, 1'b0);
        do_access(1'b1, 16'h0010, 16'h5555, 2'b00, 2, 16'h0F0F, 1'b0);
        check("dout_after_wr", mpu_data_out, 16'hA55A);

        // Simultaneous strobes
        n0 = n_req;
        mpu_rd_n = 1'b0;
        mpu_wr_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("both_idle", {core_req, mpu_busy}, 2'b00);
        end
        check("both_no_req", n_req, n0);
        mpu_rd_n = 1'b1;
        mpu_wr_n = 1'b1;
        cyc(4);

        // Early release, ack 5 cycles later
        n0 = n_req;
        do_access(1'b0, 16'h0100, 16'h0001, 2'b01, 5, 16'h1357, 1'b1);
        check("early_one_req", n_req, n0 + 1);
        cyc(2);

        // Read then immediate write with no idle gap
        n0 = n_req;
        mpu_addr_in = 16'h0200;
        mpu_data_in = 16'h0002;
        mpu_be_n    = 2'b00;
        exp_q.push_back({1'b0, 16'h0200, 16'h0002, 2'b11});
        mpu_rd_n = 1'b0;
        wait_req();
        core_ack   = 1'b1;
        core_rdata = 16'h2468;
        cyc(1);
        core_ack = 1'b0;
        check("b2b_rd_data", mpu_data_out, 16'h2468);
        mpu_rd_n = 1'b1;
        mpu_wr_n = 1'b0;
        cyc(10);
        check("b2b_one_req", n_req, n0 + 1);
        check("b2b_busy", mpu_busy, 1);
        mpu_wr_n = 1'b1;
        wait_idle();

        // Reset while a request is outstanding
        n0 = n_req;
        mpu_addr_in = 16'h0300;
        mpu_data_in = 16'h3333;
        exp_q.push_back({1'b1, 16'h0300, 16'h3333, 2'b11});
        mpu_wr_n = 1'b0;
        wait_req();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_req", core_req, 0);
        check("midrst_busy", mpu_busy, 1);
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        check("held_no_req", n_req, n0 + 1);
        check("held_idle", mpu_busy, 0);
        check("midrst_dout", mpu_data_out, 0);
        mpu_wr_n = 1'b1;
        cyc(4);
        do_access(1'b1, 16'h0301, 16'h7777, 2'b01, 1, 16'h0000, 1'b0);
        check("rearm_req", n_req, n0 + 2);

        cyc(3);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
